// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: F/D record, opcode/funct encodings,
// fault status codes and the fetch FSM state.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_ADR = 2'd1,
    STAT_INS = 2'd2
  } stat_e;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0a,
    OP_SLTIU   = 6'h0b,
    OP_ANDI    = 6'h0c,
    OP_ORI     = 6'h0d,
    OP_XORI    = 6'h0e,
    OP_LUI     = 6'h0f,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2b
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_SRA  = 6'h03,
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2a,
    FN_SLTU = 6'h2b
  } funct_e;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } fetch_state_e;

  // F/D pipeline record; an all-zero record is a nop with STAT_AOK
  typedef struct packed {
    stat_e       stat;
    logic [31:0] pc;
    logic [31:0] valP;
    logic [5:0]  opcode;
    logic [4:0]  rA;
    logic [4:0]  rB;
    logic [4:0]  rC;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] valC;
  } plr_d;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_SPECIAL, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_stage_predecode.sv
// Combinational pre-decode of one fetched word into the F/D record.
module fetch_stage_predecode
  import fetch_stage_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_pc,
  output plr_d        o_rec
);

  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic [31:0] w_pc4;

  assign w_sext = {{16{i_word[15]}}, i_word[15:0]};
  assign w_zext = {16'h0000, i_word[15:0]};
  assign w_pc4  = i_pc + 32'd4;

  // Field split plus opcode-dependent constant extraction
  always_comb begin
    o_rec        = '0;
    o_rec.stat   = op_supported(i_word[31:26]) ? STAT_AOK : STAT_INS;
    o_rec.pc     = i_pc;
    o_rec.valP   = i_pc;
    o_rec.opcode = i_word[31:26];
    o_rec.rA     = i_word[25:21];
    o_rec.rB     = i_word[20:16];
    o_rec.rC     = i_word[15:11];
    o_rec.shamt  = i_word[10:6];
    o_rec.funct  = i_word[5:0];
    case (i_word[31:26])
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: o_rec.valC = w_sext;
      OP_ANDI, OP_ORI, OP_XORI:                  o_rec.valC = w_zext;
      OP_LUI:                                    o_rec.valC = {i_word[15:0], 16'h0000};
      OP_BEQ, OP_BNE:                            o_rec.valC = {w_sext[29:0], 2'b00};
      OP_JAL:                                    o_rec.valC = {w_pc4[31:28], i_word[25:0], 2'b00};
      default:                                   o_rec.valC = '0;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage and F/D register: owns the PC, runs one ibus transaction at a
// time, pre-decodes the returned word and honours stall/bubble/redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        stall_D,
  input  logic        bubble_D,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output plr_d        r_D,
  output logic        fetch_halted
);

  fetch_state_e r_state, w_state_nx;
  logic [31:0]  r_fetch_pc, w_pc_nx;
  logic [31:0]  r_redir_pc, w_redir_pc_nx;
  logic         r_pending, w_pend_nx;
  plr_d         r_hold, w_hold_nx;
  plr_d         w_rd_nx;
  plr_d         w_pd;
  plr_d         w_adr_rec;
  logic         w_redir;
  logic         w_take;

  fetch_stage_predecode u_predecode (
    .i_word (iresp_data),
    .i_pc   (r_fetch_pc),
    .o_rec  (w_pd)
  );

  assign w_redir      = redirect_valid && !stall_D;
  assign w_take       = !stall_D && !bubble_D;
  assign fetch_halted = (r_state == S_HALT);

  // Next-state, PC, hold register and F/D record selection
  always_comb begin
    w_state_nx     = r_state;
    w_pc_nx        = r_fetch_pc;
    w_redir_pc_nx  = r_redir_pc;
    w_pend_nx      = r_pending;
    w_hold_nx      = r_hold;
    w_rd_nx        = stall_D ? r_D : '0;
    ireq_valid     = 1'b0;
    ireq_addr      = r_fetch_pc;
    w_adr_rec      = '0;
    w_adr_rec.stat = STAT_ADR;
    w_adr_rec.pc   = r_fetch_pc;
    w_adr_rec.valP = r_fetch_pc;
    case (r_state)
      S_REQ: begin
        if (w_redir) begin
          w_pend_nx     = 1'b1;
          w_redir_pc_nx = redirect_pc;
        end
        if (r_fetch_pc[1:0] != 2'b00) begin
          if (w_take) begin
            w_rd_nx    = w_adr_rec;
            w_state_nx = S_HALT;
          end
        end else begin
          ireq_valid = resetn;
          if (ireq_ready) w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iresp_valid) begin
          w_pc_nx   = w_redir ? redirect_pc : (r_pending ? r_redir_pc : r_fetch_pc + 32'd4);
          w_pend_nx = 1'b0;
          if (w_take) begin
            w_rd_nx    = w_pd;
            w_state_nx = (w_pd.stat == STAT_AOK) ? S_REQ : S_HALT;
          end else begin
            // a bubble must not drop the word, so it parks in the hold reg too
            w_hold_nx  = w_pd;
            w_state_nx = S_HOLD;
          end
        end else if (w_redir) begin
          w_pend_nx     = 1'b1;
          w_redir_pc_nx = redirect_pc;
        end
      end
      S_HOLD: begin
        // delay slot already captured and fetch_pc already advanced: retarget directly
        if (w_redir) w_pc_nx = redirect_pc;
        if (w_take) begin
          w_rd_nx    = r_hold;
          w_state_nx = (r_hold.stat == STAT_AOK) ? S_REQ : S_HALT;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_redir_pc <= '0;
      r_pending  <= 1'b0;
      r_hold     <= '0;
      r_D        <= '0;
    end else begin
      assert (!(stall_D && bubble_D));
      r_state    <= w_state_nx;
      r_fetch_pc <= w_pc_nx;
      r_redir_pc <= w_redir_pc_nx;
      r_pending  <= w_pend_nx;
      r_hold     <= w_hold_nx;
      r_D        <= w_rd_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random ibus/hazard stimulus against a transaction
// level reference model, plus directed redirect/fault/reset scenarios.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready = 1'b0;
  logic        iresp_valid = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        stall_D = 1'b0;
  logic        bubble_D = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  plr_d        r_D;
  logic        fetch_halted;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .stall_D(stall_D), .bubble_D(bubble_D),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .r_D(r_D), .fetch_halted(fetch_halted)
  );

  int unsigned n_cmp = 0, n_bad = 0;

  // stimulus knobs
  int unsigned p_stall = 0, p_bubble = 0, p_redir = 0, p_rst = 0;
  int unsigned rdy_pct = 100, min_lat = 1, max_lat = 1;
  logic        allow_ins = 1'b0;
  logic        force_redir = 1'b0, force_rst = 1'b0;
  logic [31:0] force_pc = '0;
  int unsigned force_stall_n = 0, force_bubble_n = 0;

  // ibus responder
  int unsigned rsp_cnt = 0;
  logic [31:0] rsp_addr = '0;

  // reference model
  plr_d        m_rd;
  logic        m_halt, m_pend_v, m_out_v, m_got;
  logic [31:0] m_next, m_pend, m_out_addr;
  int unsigned halt_age;
  logic [31:0] acc_log[$];
  plr_d        load_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0]  ops[14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0a,
                             6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
    logic [31:0] h;
    case (a)
      32'hbfc0_0000: return 32'h2401_0005;
      32'hbfc0_0004: return 32'h3c01_ffff;
      32'hbfc0_0008: return 32'h3421_ffff;
      32'h0000_0100: return 32'h1022_0040;
      32'h0000_0300: return 32'hfc00_0000;
      default: ;
    endcase
    h = (a ^ (a >> 16)) * 32'h045d_9f3b;
    h = h ^ (h >> 16);
    if (allow_ins && h[31:27] == 5'd0) return {2'b11, h[3:0], h[25:0]};
    return {ops[int'(h[30:27]) % 14], h[25:0]};
  endfunction

  // Reference pre-decode from the instruction-format rules
  function automatic plr_d ref_decode(input logic [31:0] w, input logic [31:0] pc);
    plr_d r;
    int   imm;
    logic [31:0] u;
    r = '0;
    r.pc = pc; r.valP = pc;
    r.opcode = w[31:26]; r.rA = w[25:21]; r.rB = w[20:16];
    r.rC = w[15:11]; r.shamt = w[10:6]; r.funct = w[5:0];
    imm = int'($signed(w[15:0]));
    u = w & 32'h0000_ffff;
    case (int'(w[31:26]))
      9, 10, 11, 35, 43: r.valC = imm;
      12, 13, 14:        r.valC = u;
      15:                r.valC = u * 32'd65536;
      4, 5:              r.valC = imm * 4;
      3:                 r.valC = ((pc + 32'd4) & 32'hf000_0000) | ((w & 32'h03ff_ffff) * 32'd4);
      0, 2:              r.valC = '0;
      default:           r.stat = STAT_INS;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = '0; m_halt = 1'b0; m_pend_v = 1'b0; m_out_v = 1'b0; m_got = 1'b0;
    m_next = 32'hbfc0_0000; m_pend = '0; m_out_addr = '0; halt_age = 0;
    acc_log.delete(); load_log.delete();
  endtask

  task automatic model_step();
    plr_d rec;
    logic avail, acc;
    if (!resetn) begin
      model_reset();
      return;
    end
    acc   = !m_halt && !m_out_v && (m_next[1:0] == 2'b00) && ireq_ready;
    avail = 1'b0;
    rec   = '0;
    if (m_out_v && (m_got || iresp_valid)) begin
      avail = 1'b1;
      rec   = ref_decode(mem_word(m_out_addr), m_out_addr);
    end else if (!m_halt && !m_out_v && m_next[1:0] != 2'b00) begin
      avail = 1'b1;
      rec.stat = STAT_ADR; rec.pc = m_next; rec.valP = m_next;
    end
    if (m_out_v && iresp_valid) m_got = 1'b1;
    if (redirect_valid && !stall_D && !m_halt) begin
      if (m_out_v) m_next = redirect_pc;
      else begin m_pend_v = 1'b1; m_pend = redirect_pc; end
    end
    if (stall_D) ;
    else if (bubble_D) m_rd = '0;
    else if (avail) begin
      m_rd = rec;
      load_log.push_back(rec);
      if (rec.stat != STAT_AOK) m_halt = 1'b1;
      m_out_v = 1'b0; m_got = 1'b0;
    end else m_rd = '0;
    if (acc) begin
      acc_log.push_back(m_next);
      m_out_v = 1'b1; m_out_addr = m_next; m_got = 1'b0;
      m_next = m_pend_v ? m_pend : m_next + 32'd4;
      m_pend_v = 1'b0;
    end
    halt_age = m_halt ? halt_age + 1 : 0;
  endtask

  // Per-cycle comparison of every DUT output against the model
  task automatic compare_cycle();
    logic exp_v;
    exp_v = resetn && !m_halt && !m_out_v && (m_next[1:0] == 2'b00);
    check("ireq_valid", ireq_valid, exp_v);
    if (exp_v) check("ireq_addr", ireq_addr, m_next);
    check("r_D", r_D, m_rd);
    check("fetch_halted", fetch_halted, m_halt);
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned r;
    logic [31:0] t;
    r = $urandom_range(0, 19);
    t = {20'h0, 10'($urandom), 2'b00};
    if (r == 0) t = 32'hffff_fffc;
    else if (r == 1 && allow_ins) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic drive();
    int unsigned r;
    resetn = !(force_rst || ($urandom_range(0, 999) < p_rst) || halt_age > 6);
    force_rst = 1'b0;
    r = $urandom_range(0, 99);
    if (force_stall_n > 0) begin
      stall_D = 1'b1; bubble_D = 1'b0; force_stall_n--;
    end else if (force_bubble_n > 0) begin
      stall_D = 1'b0; bubble_D = 1'b1; force_bubble_n--;
    end else begin
      stall_D  = (r < p_stall);
      bubble_D = !stall_D && (r < p_stall + p_bubble);
    end
    if (force_redir) begin
      stall_D = 1'b0; bubble_D = 1'b0;
      redirect_valid = 1'b1; redirect_pc = force_pc;
    end else begin
      redirect_valid = ($urandom_range(0, 99) < p_redir);
      redirect_pc = rand_target();
    end
    force_redir = 1'b0;
    iresp_valid = 1'b0;
    iresp_data  = $urandom;
    if (!resetn) rsp_cnt = 0;
    else if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        iresp_valid = 1'b1;
        iresp_data  = mem_word(rsp_addr);
      end
    end
    ireq_ready = ($urandom_range(0, 99) < rdy_pct);
    #1;
    if (resetn && ireq_valid && ireq_ready) begin
      rsp_addr = ireq_addr;
      rsp_cnt  = $urandom_range(min_lat, max_lat);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_cycle();
    drive();
    @(posedge clk);
    model_step();
  endtask

  task automatic run_until_pc(input logic [31:0] pc, input string name);
    int unsigned n = 0;
    while (m_rd.pc != pc && n < 60) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (m_rd.pc != pc) begin
      n_bad++;
      $display("FAIL %s: pc %h never reached D (last %h)", name, pc, m_rd.pc);
    end
  endtask

  task automatic redirect_when(input logic [31:0] d_pc, input logic [31:0] tgt, input string name);
    run_until_pc(d_pc, name);
    force_redir = 1'b1;
    force_pc    = tgt;
  endtask

  function automatic int find_addr(input logic [31:0] a);
    foreach (acc_log[i]) if (acc_log[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < 0 || i >= acc_log.size()) return 32'hdead_beef;
    return acc_log[i];
  endfunction

  task automatic restart();
    force_rst = 1'b1;
    cycle();
  endtask

  initial begin
    plr_d d;
    int   i;
    model_reset();

    // literals pinning the reference decoder
    d = ref_decode(32'h2401_0005, 32'h0000_0040);
    check("ref_addiu_op", d.opcode, OP_ADDIU);
    check("ref_addiu_rB", d.rB, 5'd1);
    check("ref_addiu_valC", d.valC, 32'h0000_0005);
    d = ref_decode(32'h3c01_ffff, 32'h0);
    check("ref_lui_valC", d.valC, 32'hffff_0000);
    d = ref_decode(32'h3421_ffff, 32'h0);
    check("ref_ori_valC", d.valC, 32'h0000_ffff);
    d = ref_decode(32'h1022_fffe, 32'h0000_0100);
    check("ref_beq_valC", d.valC, 32'hffff_fff8);
    d = ref_decode(32'h0c00_0010, 32'hbfc0_0010);
    check("ref_jal_valC", d.valC, 32'hb000_0040);
    d = ref_decode(32'hfc00_0000, 32'h0);
    check("ref_op3f_stat", d.stat, STAT_INS);

    // straight-line fetch after reset, ready=1, 1-cycle response
    restart();
    repeat (8) cycle();
    check("addr0", acc_at(0), 32'hbfc0_0000);
    check("addr1", acc_at(1), 32'hbfc0_0004);
    check("addr2", acc_at(2), 32'hbfc0_0008);
    check("loads_in_8", load_log.size(), 32'd4);
    if (load_log.size() >= 3) begin
      check("addiu_valC", load_log[0].valC, 32'h5);
      check("addiu_rB", load_log[0].rB, 5'd1);
      check("lui_valC", load_log[1].valC, 32'hffff_0000);
      check("lui_pc", load_log[1].pc, 32'hbfc0_0004);
      check("ori_valC", load_log[2].valC, 32'h0000_ffff);
    end

    // branch chain with delay slots, ending in a misaligned target
    restart();
    redirect_when(32'hbfc0_0000, 32'h0000_0100, "to_100");
    redirect_when(32'h0000_0100, 32'h0000_0200, "to_200");
    redirect_when(32'h0000_0200, 32'h0000_0203, "to_203");
    run_until_pc(32'h0000_0203, "adr_fault");
    i = find_addr(32'h0000_0100);
    check("delay_slot_104", acc_at(i + 1), 32'h0000_0104);
    check("target_200", acc_at(i + 2), 32'h0000_0200);
    check("no_108", find_addr(32'h0000_0108) < 0, 1'b1);
    check("slot_204_last", acc_at(acc_log.size() - 1), 32'h0000_0204);
    check("adr_stat", m_rd.stat, STAT_ADR);
    check("adr_halted", m_halt, 1'b1);

    // PC wrap-around at the top of the address space
    restart();
    redirect_when(32'hbfc0_0000, 32'hffff_fffc, "to_top");
    repeat (8) cycle();
    check("wrap_fffc", acc_at(2), 32'hffff_fffc);
    check("wrap_0", acc_at(3), 32'h0000_0000);

    // unsupported opcode halts
    restart();
    redirect_when(32'hbfc0_0000, 32'h0000_0300, "to_300");
    run_until_pc(32'h0000_0300, "ins_fault");
    check("ins_stat", m_rd.stat, STAT_INS);
    check("ins_halted", m_halt, 1'b1);

    // stall then bubble while a response is parked
    restart();
    min_lat = 2; max_lat = 2;
    repeat (3) cycle();
    force_stall_n = 3; force_bubble_n = 1;
    repeat (10) cycle();

    // reset while waiting on a slow response
    min_lat = 3; max_lat = 3;
    restart();
    repeat (2) cycle();
    check("mid_wait", m_out_v && !m_got, 1'b1);
    restart();
    check("rst_model_rd", m_rd, '0);
    repeat (4) cycle();
    check("rst_refetch", acc_at(0), 32'hbfc0_0000);

    // randomized traffic
    allow_ins = 1'b1;
    p_stall = 20; p_bubble = 10; p_redir = 8; p_rst = 5;
    rdy_pct = 60; min_lat = 1; max_lat = 4;
    restart();
    repeat (3000) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
